// File: rtl/bullet_motion_ctrl.sv
// Player bullet controller: latches fire, launches from the gun, moves up once per frame.
// Optional re-fire cooldown is enabled by defining BULLET_COOLDOWN_EN.
module bullet_motion_ctrl #(
    parameter int V_ACTIVE        = 480,
    parameter int LAUNCH_Y        = 440,
    parameter int SPEED           = 6,
    parameter int X_MAX           = 632,
    parameter int PARK_Y          = -128,
    parameter int HIT_FRAMES      = 8,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              fire,
    input  logic [9:0]        gun_x,
    input  logic              hit,
    output logic [9:0]        pos_x,
    output logic signed [9:0] pos_y,
    output logic              active,
    output logic              hit_event,
    output logic [7:0]        shot_count
);

`ifdef BULLET_COOLDOWN_EN
    typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT_HOLD, S_COOLDOWN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT_HOLD} state_t;
`endif

    state_t             state_q, state_d;
    logic [9:0]         vcount_q, vcount_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic               fire_pend_q, fire_pend_d;
    logic               hit_pend_q, hit_pend_d;
    logic [9:0]         pos_x_q, pos_x_d;
    logic signed [9:0]  pos_y_q, pos_y_d;
    logic               active_q, active_d;
    logic               hit_event_q, hit_event_d;
    logic [7:0]         shot_count_q, shot_count_d;

    logic               tick;
    logic               park;
    logic signed [10:0] next_y;
    logic [9:0]         clamp_x;

    logic unused_hcount;
    assign unused_hcount = ^hcount;

    always_comb begin
        state_d      = state_q;
        vcount_d     = vcount;
        frame_cnt_d  = frame_cnt_q;
        fire_pend_d  = fire_pend_q;
        hit_pend_d   = hit_pend_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        hit_event_d  = 1'b0;
        shot_count_d = shot_count_q;
        park         = 1'b0;

        // Rising into the first blanking line marks the single update point per frame.
        tick    = (vcount == 10'(V_ACTIVE)) && (vcount_q != 10'(V_ACTIVE));
        next_y  = {pos_y_q[9], pos_y_q} - 11'(SPEED);
        clamp_x = (gun_x > 10'(X_MAX)) ? 10'(X_MAX) : gun_x;

        if (!tick) begin
            if (state_q == S_IDLE && fire) fire_pend_d = 1'b1;
            if (state_q == S_FLY && hit)   hit_pend_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    fire_pend_d = 1'b0;
                    if (fire_pend_q || fire) begin
                        state_d      = S_FLY;
                        pos_y_d      = 10'(LAUNCH_Y);
                        pos_x_d      = clamp_x;
                        shot_count_d = shot_count_q + 8'd1;
                    end
                end
                S_FLY: begin
                    hit_pend_d = 1'b0;
                    // A hit takes priority over leaving the screen on the same frame.
                    if (hit_pend_q || hit) begin
                        state_d     = S_HIT_HOLD;
                        frame_cnt_d = 8'd0;
                        hit_event_d = 1'b1;
                    end else if (next_y < -11'sd10) begin
                        park = 1'b1;
                    end else begin
                        pos_y_d = next_y[9:0];
                    end
                end
                S_HIT_HOLD: begin
                    if (frame_cnt_q == 8'(HIT_FRAMES - 1)) park = 1'b1;
                    else frame_cnt_d = frame_cnt_q + 8'd1;
                end
`ifdef BULLET_COOLDOWN_EN
                S_COOLDOWN: begin
                    if (frame_cnt_q == 8'(COOLDOWN_FRAMES - 1)) begin
                        state_d     = S_IDLE;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (park) begin
            pos_x_d     = 10'd0;
            pos_y_d     = 10'(PARK_Y);
            frame_cnt_d = 8'd0;
`ifdef BULLET_COOLDOWN_EN
            state_d     = S_COOLDOWN;
`else
            state_d     = S_IDLE;
`endif
        end

        active_d = (state_d == S_FLY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            vcount_q     <= 10'd0;
            frame_cnt_q  <= 8'd0;
            fire_pend_q  <= 1'b0;
            hit_pend_q   <= 1'b0;
            pos_x_q      <= 10'd0;
            pos_y_q      <= 10'(PARK_Y);
            active_q     <= 1'b0;
            hit_event_q  <= 1'b0;
            shot_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            vcount_q     <= vcount_d;
            frame_cnt_q  <= frame_cnt_d;
            fire_pend_q  <= fire_pend_d;
            hit_pend_q   <= hit_pend_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            active_q     <= active_d;
            hit_event_q  <= hit_event_d;
            shot_count_q <= shot_count_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign active     = active_q;
    assign hit_event  = hit_event_q;
    assign shot_count = shot_count_q;

endmodule

// File: tb/tb_bullet_motion_ctrl.sv
// Scoreboard bench for bullet_motion_ctrl: a frame-level model predicts every cycle's outputs,
// a monitor compares them after each clock edge.
module tb_bullet_motion_ctrl;

`ifdef BULLET_COOLDOWN_EN
    localparam bit COOL_EN = 1'b1;
`else
    localparam bit COOL_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        hcount;
    logic [9:0]        vcount;
    logic              fire;
    logic [9:0]        gun_x;
    logic              hit;
    logic [9:0]        pos_x;
    logic signed [9:0] pos_y;
    logic              active;
    logic              hit_event;
    logic [7:0]        shot_count;

    always #5 clk = ~clk;

    bullet_motion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .fire       (fire),
        .gun_x      (gun_x),
        .hit        (hit),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .active     (active),
        .hit_event  (hit_event),
        .shot_count (shot_count)
    );

    typedef struct {
        int x;
        int y;
        bit act;
        bit he;
        int shots;
        bit rep;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: 0 = idle, 1 = flying, 2 = frozen after hit, 3 = cooling down
    int m_mode, m_x, m_y, m_shots, m_left, m_prev_v, launches;
    bit m_fire_wait, m_hit_wait;

    task automatic end_flight();
        m_y = -128;
        m_x = 0;
        if (COOL_EN) begin
            m_mode = 3;
            m_left = 15;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic model_step(input bit r, input bit f, input bit h, input int gx, input int v);
        exp_t e;
        bit   tick;
        e.he  = 1'b0;
        e.rep = 1'b0;
        if (r) begin
            m_mode = 0; m_x = 0; m_y = -128; m_shots = 0;
            m_fire_wait = 0; m_hit_wait = 0; m_left = 0; m_prev_v = 0;
            e.rep = 1'b1;
        end else begin
            tick = (v == 480) && (m_prev_v != 480);
            m_prev_v = v;
            if (!tick) begin
                if (m_mode == 0 && f) m_fire_wait = 1;
                if (m_mode == 1 && h) m_hit_wait = 1;
            end else begin
                e.rep = 1'b1;
                if (m_mode == 0) begin
                    if (m_fire_wait || f) begin
                        m_mode  = 1;
                        m_y     = 440;
                        m_x     = (gx < 632) ? gx : 632;
                        m_shots = (m_shots + 1) % 256;
                        launches++;
                    end
                    m_fire_wait = 0;
                end else if (m_mode == 1) begin
                    if (m_hit_wait || h) begin
                        m_mode = 2;
                        m_left = 8;
                        e.he   = 1'b1;
                    end else if (m_y - 6 < -10) begin
                        end_flight();
                    end else begin
                        m_y = m_y - 6;
                    end
                    m_hit_wait = 0;
                end else if (m_mode == 2) begin
                    m_left--;
                    if (m_left == 0) end_flight();
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        end
        e.x     = m_x;
        e.y     = m_y;
        e.act   = (m_mode == 1);
        e.shots = m_shots;
        sb.push_back(e);
    endtask

    task automatic drive(input bit r, input bit f, input bit h, input int gx, input int v);
        reset  = r;
        fire   = f;
        hit    = h;
        gun_x  = 10'(gx);
        vcount = 10'(v);
        hcount = 10'($urandom_range(0, 799));
        model_step(r, f, h, gx, v);
        @(posedge clk);
        #1;
    endtask

    // One short synthetic frame: a few visible lines, 1-3 cycles on the first blanking line, one more blanking line.
    task automatic frame(input int fp, input int hp, input int gx);
        int n;
        int g;
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) begin
            g = (gx < 0) ? int'($urandom_range(0, 1023)) : gx;
            drive(0, $urandom_range(0, 99) < fp, $urandom_range(0, 99) < hp, g, $urandom_range(0, 479));
        end
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            g = (gx < 0) ? int'($urandom_range(0, 1023)) : gx;
            drive(0, $urandom_range(0, 99) < fp, $urandom_range(0, 99) < hp, g, 480);
        end
        g = (gx < 0) ? int'($urandom_range(0, 1023)) : gx;
        drive(0, $urandom_range(0, 99) < fp, $urandom_range(0, 99) < hp, g, $urandom_range(481, 524));
    endtask

    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                bad = 1'b0;
                tests++;
                if (int'(pos_x) != e.x) begin
                    $display("FAIL pos_x cycle %0d: got %0d expected %0d", cyc, pos_x, e.x);
                    bad = 1'b1;
                end
                if (int'(pos_y) != e.y) begin
                    $display("FAIL pos_y cycle %0d: got %0d expected %0d", cyc, pos_y, e.y);
                    bad = 1'b1;
                end
                if (active !== e.act) begin
                    $display("FAIL active cycle %0d: got %0d expected %0d", cyc, active, e.act);
                    bad = 1'b1;
                end
                if (hit_event !== e.he) begin
                    $display("FAIL hit_event cycle %0d: got %0d expected %0d", cyc, hit_event, e.he);
                    bad = 1'b1;
                end
                if (int'(shot_count) != e.shots) begin
                    $display("FAIL shot_count cycle %0d: got %0d expected %0d", cyc, shot_count, e.shots);
                    bad = 1'b1;
                end
                if (bad) fails++;
                if (e.rep)
                    $display("[TB] cycle %0d update: pos_x=%0d pos_y=%0d active=%0d hit_event=%0d shots=%0d",
                             cyc, pos_x, pos_y, active, hit_event, shot_count);
            end
        end
    end

    initial begin
        int nfr;
        repeat (3) drive(1, 0, 0, 0, 10);

        // Launch from vcount 100 at x=300, then fly off the top; fire during flight is dropped.
        drive(0, 1, 0, 300, 100);
        repeat (40) frame(0, 0, 300);
        repeat (30) frame(40, 0, -1);
        repeat (10) frame(0, 0, -1);
        repeat (17) frame(0, 0, -1);

        // Hit reported while pos_y is 200, then the freeze and park.
        drive(0, 1, 0, 300, 100);
        repeat (41) frame(0, 0, -1);
        drive(0, 0, 1, 0, 200);
        repeat (10) frame(0, 0, -1);
        repeat (17) frame(0, 0, -1);

        // Out-of-range gun column gets clamped.
        drive(0, 1, 0, 700, 100);
        frame(0, 0, 700);
        frame(0, 100, -1);
        repeat (10) frame(0, 0, -1);
        repeat (17) frame(0, 0, -1);

        // Fire held continuously across the end of a hit freeze.
        drive(0, 1, 0, 50, 100);
        frame(0, 0, -1);
        frame(0, 100, -1);
        repeat (30) frame(100, 0, -1);

        // Reset in the middle of a flight at pos_y 200.
        drive(1, 0, 0, 0, 10);
        drive(0, 1, 0, 300, 100);
        repeat (41) frame(0, 0, -1);
        drive(1, 0, 0, 0, 200);
        repeat (3) frame(0, 0, -1);

        // Random traffic until the shot counter has wrapped.
        drive(1, 0, 0, 0, 10);
        launches = 0;
        nfr = 0;
        while (launches < 260 && nfr < 7500) begin
            frame($urandom_range(0, 30), $urandom_range(10, 40), -1);
            nfr++;
        end

        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
            fails++;
        end
        tests++;
        if (launches < 256) begin
            $display("FAIL wrap_coverage: got %0d launches expected at least 256", launches);
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
